// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pkg;

  typedef enum logic [2:0] {DATA, PAD, ZERO, LEN_HI, LEN_LO} state_t;

  localparam int         WORDS_PER_BLK   = 16;
  localparam int         BYTES_PER_WORD  = 4;
  localparam int         LEN_WORD_HI_IDX = 14;
  localparam logic [7:0] PAD_BYTE        = 8'h80;

endpackage

// File: rtl/sha1_word_pack.sv
// Byte to 32-bit big-endian word packer; flush emits the partial word
// with the 0x80 pad byte in the next free lane.
module sha1_word_pack
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_word,
  output logic [1:0]  byte_idx,
  output logic        full
);

  logic [BYTES_PER_WORD-1:0][7:0] asm_q, cmp_w, pad_w;
  logic [1:0] idx_q;
  logic       full_q;

  assign in_ready = !full_q;
  assign byte_idx = idx_q;
  assign full     = full_q;

  // Lane 3 carries the first byte of the word; byte k lands in lane 3-k.
  always_comb begin
    cmp_w = asm_q;
    cmp_w[0] = in_data;
    pad_w = '0;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (int'(idx_q) > BYTES_PER_WORD-1-l)       pad_w[l] = asm_q[l];
      else if (int'(idx_q) == BYTES_PER_WORD-1-l) pad_w[l] = PAD_BYTE;
    end
  end

  assign out_valid = full_q || (in_valid && idx_q == 2'd3) || flush;
  assign out_word  = full_q ? asm_q : (flush ? pad_w : cmp_w);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      asm_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        idx_q <= idx_q + 2'd1;
        for (int l = 0; l < BYTES_PER_WORD; l++)
          if (idx_q == 2'(BYTES_PER_WORD-1-l)) asm_q[l] <= in_data;
        // Completed word parks here when the output register is still occupied.
        if (idx_q == 2'd3 && !out_ready) full_q <= 1'b1;
      end
      if (full_q && out_ready)      full_q <= 1'b0;
      else if (flush && out_ready)  idx_q  <= '0;
    end
  end

endmodule

// File: rtl/sha1_pad.sv
// SHA-1 message padder feeding sha1core one 32-bit word at a time.
// Optional SHA1_PAD_BLKCNT_EN adds a per-message completed-block counter.
module sha1_pad
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  input  logic        core_busy,
  output logic        core_wr,
  output logic [31:0] core_data,
`ifdef SHA1_PAD_BLKCNT_EN
  output logic [31:0] blk_count,
`endif
  output logic        done
);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic [3:0]       word_idx, ld_idx;
  logic             rdy_en, lo_ld;
  logic             xfer, out_free, acc, empty_acc;
  logic             pk_ready, pk_out_ready, pk_out_valid, pk_full;
  logic [31:0]      pk_word;
  logic [1:0]       pk_idx;

  assign xfer      = core_wr && !core_busy;
  assign out_free  = !core_wr || xfer;
  assign in_ready  = rdy_en && state == DATA && !done && pk_ready;
  assign acc       = in_valid && in_ready && !in_empty;
  assign empty_acc = in_valid && in_ready && in_empty;
  assign len64     = 64'(len);
  assign pk_out_ready = out_free && (state == DATA || state == PAD);

  sha1_word_pack u_pack (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (acc),
    .in_data   (in_data),
    .in_ready  (pk_ready),
    .flush     (state == PAD),
    .out_ready (pk_out_ready),
    .out_valid (pk_out_valid),
    .out_word  (pk_word),
    .byte_idx  (pk_idx),
    .full      (pk_full)
  );

  // ld_idx tracks the block position of the word being loaded, which can run
  // one ahead of word_idx (transferred words) while the core is busy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= DATA;
      len       <= '0;
      word_idx  <= '0;
      ld_idx    <= '0;
      core_wr   <= 1'b0;
      core_data <= '0;
      done      <= 1'b0;
      rdy_en    <= 1'b0;
      lo_ld     <= 1'b0;
    end else begin
      done   <= 1'b0;
      rdy_en <= 1'b1;
      if (xfer) begin
        word_idx <= word_idx + 4'd1;
        core_wr  <= 1'b0;
      end
      if (acc) len <= len + LEN_W'(8);
      case (state)
        DATA: begin
          if (pk_out_valid && out_free) begin
            core_wr   <= 1'b1;
            core_data <= pk_word;
            ld_idx    <= ld_idx + 4'd1;
          end
          if ((acc && in_last) || empty_acc) state <= PAD;
        end
        PAD: if (out_free) begin
          core_wr   <= 1'b1;
          core_data <= pk_word;
          ld_idx    <= ld_idx + 4'd1;
          if (!pk_full)
            state <= (ld_idx == 4'(LEN_WORD_HI_IDX-1)) ? LEN_HI : ZERO;
        end
        ZERO: if (out_free) begin
          core_wr   <= 1'b1;
          core_data <= '0;
          ld_idx    <= ld_idx + 4'd1;
          if (ld_idx == 4'(LEN_WORD_HI_IDX-1)) state <= LEN_HI;
        end
        LEN_HI: if (out_free) begin
          core_wr   <= 1'b1;
          core_data <= len64[63:32];
          ld_idx    <= ld_idx + 4'd1;
          state     <= LEN_LO;
        end
        LEN_LO: begin
          if (!lo_ld) begin
            if (out_free) begin
              core_wr   <= 1'b1;
              core_data <= len64[31:0];
              ld_idx    <= ld_idx + 4'd1;
              lo_ld     <= 1'b1;
            end
          end else if (xfer) begin
            done     <= 1'b1;
            state    <= DATA;
            len      <= '0;
            word_idx <= '0;
            ld_idx   <= '0;
            lo_ld    <= 1'b0;
          end
        end
        default: state <= DATA;
      endcase
    end
  end

`ifdef SHA1_PAD_BLKCNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                 blk_count <= '0;
    else if (done)             blk_count <= '0;
    else if (xfer && word_idx == 4'(WORDS_PER_BLK-1) && blk_count != '1)
                               blk_count <= blk_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad: word tables per message, busy stall and mid-message reset.
module tb_sha1_pad;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0, core_busy = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, core_wr, done;
  logic [31:0] core_data;
`ifdef SHA1_PAD_BLKCNT_EN
  logic [31:0] blk_count;
`endif

  always #5 clk = ~clk;

  sha1_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .core_busy (core_busy),
    .core_wr   (core_wr),
    .core_data (core_data),
`ifdef SHA1_PAD_BLKCNT_EN
    .blk_count (blk_count),
`endif
    .done      (done)
  );

  // Core model: every accepted word and done pulse is recorded.
  logic [31:0] got[$];
  int          done_cnt = 0;
  always @(posedge clk)
    if (nrst) begin
      if (core_wr && !core_busy) got.push_back(core_data);
      if (done) done_cnt <= done_cnt + 1;
    end

  typedef struct { int t; int idx; logic [31:0] exp; } vec_t;
  vec_t vt[$];
  int pass_cnt = 0, tot_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(string name);
    tot_cnt++;
    $display("FAIL %s: timeout or missing data", name);
  endtask

  function automatic logic [7:0] msg_byte(int kind, int i);
    return (kind == 0) ? 8'(32'h61 + i/4 + i%4) : 8'h61;
  endfunction

  task automatic wait_ready(string name);
    int g = 0;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) fail_now(name);
  endtask

  task automatic send(int n, int kind, bit last, bit empty);
    if (empty) begin
      @(negedge clk); in_valid = 1'b1; in_empty = 1'b1;
      wait_ready("empty_ready");
      @(posedge clk);
    end else
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        in_valid = 1'b1; in_data = msg_byte(kind, i); in_last = last && (i == n-1);
        wait_ready("byte_ready");
        @(posedge clk);
      end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic run_msg(int t, int n, int kind, bit empty, int nwords);
    int wb = got.size();
    int db = done_cnt;
    int g = 0;
    send(n, kind, 1'b1, empty);
    while (done_cnt == db && g < 600) begin @(negedge clk); g++; end
    if (g >= 600) fail_now($sformatf("t%0d_done", t));
    repeat (3) @(negedge clk);
    check($sformatf("t%0d_nwords", t), 32'(got.size() - wb), 32'(nwords));
    check($sformatf("t%0d_ndone", t), 32'(done_cnt - db), 32'd1);
    foreach (vt[k])
      if (vt[k].t == t) begin
        if (wb + vt[k].idx < got.size())
          check($sformatf("t%0d_w%0d", t, vt[k].idx), got[wb + vt[k].idx], vt[k].exp);
        else fail_now($sformatf("t%0d_w%0d", t, vt[k].idx));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{0, 0, 32'h61626380}); vt.push_back('{0, 1, 32'h0});
    vt.push_back('{0, 14, 32'h0});       vt.push_back('{0, 15, 32'h18});
    vt.push_back('{1, 0, 32'h80000000}); vt.push_back('{1, 1, 32'h0});
    vt.push_back('{1, 14, 32'h0});       vt.push_back('{1, 15, 32'h0});
    vt.push_back('{2, 0, 32'h61626364}); vt.push_back('{2, 1, 32'h62636465});
    vt.push_back('{2, 13, 32'h6e6f7071}); vt.push_back('{2, 14, 32'h80000000});
    vt.push_back('{2, 15, 32'h0});       vt.push_back('{2, 16, 32'h0});
    vt.push_back('{2, 29, 32'h0});       vt.push_back('{2, 30, 32'h0});
    vt.push_back('{2, 31, 32'h1c0});
    vt.push_back('{3, 0, 32'h61616161}); vt.push_back('{3, 12, 32'h61616161});
    vt.push_back('{3, 13, 32'h61616180}); vt.push_back('{3, 14, 32'h0});
    vt.push_back('{3, 15, 32'h1b8});
    vt.push_back('{4, 15, 32'h61616161}); vt.push_back('{4, 16, 32'h80000000});
    vt.push_back('{4, 17, 32'h0});       vt.push_back('{4, 30, 32'h0});
    vt.push_back('{4, 31, 32'h200});
    vt.push_back('{5, 0, 32'h61626364}); vt.push_back('{5, 6, 32'h6768696a});
    vt.push_back('{5, 7, 32'h68698000}); vt.push_back('{5, 8, 32'h0});
    vt.push_back('{5, 15, 32'hf0});
    vt.push_back('{6, 0, 32'h61626380}); vt.push_back('{6, 1, 32'h0});
    vt.push_back('{6, 15, 32'h18});

    // Reset state
    @(negedge clk);
    check("rst_core_wr", 32'(core_wr), 32'd0);
    check("rst_core_data", core_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_msg(0, 3, 0, 1'b0, 16);
    run_msg(1, 0, 0, 1'b1, 16);
    run_msg(2, 56, 0, 1'b0, 32);
    run_msg(3, 55, 1, 1'b0, 16);
    run_msg(4, 64, 1, 1'b0, 32);

    // Core stalls mid-block: output held, input back-pressured, nothing lost.
    fork
      run_msg(5, 30, 0, 1'b0, 16);
      begin
        logic [31:0] d0;
        logic        w0;
        bit          stable = 1'b1;
        repeat (10) @(negedge clk);
        core_busy = 1'b1;
        repeat (4) @(negedge clk);
        d0 = core_data; w0 = core_wr;
        repeat (15) begin
          @(negedge clk);
          if (core_data !== d0 || core_wr !== w0) stable = 1'b0;
        end
        @(negedge clk);
        check("busy_core_wr", 32'(w0), 32'd1);
        check("busy_core_data", d0, 32'h63646566);
        check("busy_stable", 32'(stable), 32'd1);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        core_busy = 1'b0;
      end
    join

    // Reset in the middle of a message, then a clean message.
    send(12, 0, 1'b0, 1'b0);
    nrst = 1'b0;
    #1;
    check("midrst_core_wr", 32'(core_wr), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_msg(6, 3, 0, 1'b0, 16);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
